// File: rtl/stdp_weight_update.sv
// Pair-based STDP learning stage feeding the synaptic weight register.
// Tracks elapsed cycles since the last pre- and post-synaptic spike,
// turns a causal spike pair into a potentiation or depression delta, and
// writes the saturated new weight to the register through a one-cycle
// strobe. Results still in flight are forwarded so that back-to-back
// updates accumulate correctly.
module stdp_weight_update #(
   parameter int weight_width = 8,
   parameter int trace_width  = 3,
   parameter int window       = 6,
   parameter int ltp_step     = 2,
   parameter int ltd_step     = 1,
   parameter int weight_max   = 255,
   parameter int weight_min   = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    active,
   input  logic                    pre_spike,
   input  logic                    post_spike,
   input  logic [weight_width-1:0] weight_q,
   output logic [weight_width-1:0] weight_d,
   output logic                    weight_en,
   output logic                    ltp_event,
   output logic                    ltd_event
);

   // Wide enough that base +/- delta can neither overflow nor wrap below zero.
   localparam int sumWidth = weight_width + trace_width + 4;

   localparam logic [trace_width-1:0]     timerExpired = trace_width'(window + 1);
   localparam logic [trace_width-1:0]     timerWindow  = trace_width'(window);
   localparam logic signed [sumWidth-1:0] upperBound   = sumWidth'(weight_max);
   localparam logic signed [sumWidth-1:0] lowerBound   = sumWidth'(weight_min);

   typedef enum logic [1:0] {
      OP_NONE,
      OP_LTP,
      OP_LTD
   } opKind;

   logic [trace_width-1:0]     preTimer;
   logic [trace_width-1:0]     postTimer;
   opKind                      detOp;
   opKind                      stageOp;
   logic [sumWidth-1:0]        detDelta;
   logic [sumWidth-1:0]        stageDelta;
   logic [weight_width-1:0]    base;
   logic [weight_width-1:0]    result;
   logic signed [sumWidth-1:0] acc;

   // Classify the current spike against the opposite timer and size the update.
   always_comb begin
      detOp    = OP_NONE;
      detDelta = '0;
      if (post_spike && !pre_spike && (preTimer <= timerWindow)) begin
         detOp    = OP_LTP;
         detDelta = sumWidth'(ltp_step * (window + 1 - int'(preTimer)));
      end else if (pre_spike && !post_spike && (postTimer <= timerWindow)) begin
         detOp    = OP_LTD;
         detDelta = sumWidth'(ltd_step * (window + 1 - int'(postTimer)));
      end
   end

   // Elapsed-time timers: a spike restarts its timer, otherwise count up to expired.
   always_ff @(posedge clk) begin
      if (reset) begin
         preTimer  <= timerExpired;
         postTimer <= timerExpired;
      end else if (active) begin
         if (pre_spike)
            preTimer <= '0;
         else if (preTimer != timerExpired)
            preTimer <= preTimer + trace_width'(1);
         if (post_spike)
            postTimer <= '0;
         else if (postTimer != timerExpired)
            postTimer <= postTimer + trace_width'(1);
      end
   end

   // First pipeline stage: capture the detected operation and its delta.
   always_ff @(posedge clk) begin
      if (reset) begin
         stageOp    <= OP_NONE;
         stageDelta <= '0;
      end else if (active) begin
         stageOp    <= detOp;
         stageDelta <= detDelta;
      end
   end

   // Apply the staged delta to the freshest weight, forwarding a write the register has not taken yet.
   always_comb begin
      base   = weight_en ? weight_d : weight_q;
      acc    = '0;
      result = '0;
      if (stageOp == OP_LTD)
         acc = $signed(sumWidth'(base)) - $signed(stageDelta);
      else
         acc = $signed(sumWidth'(base)) + $signed(stageDelta);
      if (acc > upperBound)
         result = weight_width'(weight_max);
      else if (acc < lowerBound)
         result = weight_width'(weight_min);
      else
         result = acc[weight_width-1:0];
   end

   // Second pipeline stage: registered write strobe, new weight and event pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         weight_d  <= '0;
         weight_en <= 1'b0;
         ltp_event <= 1'b0;
         ltd_event <= 1'b0;
      end else if (active) begin
         weight_en <= (stageOp != OP_NONE);
         ltp_event <= (stageOp == OP_LTP);
         ltd_event <= (stageOp == OP_LTD);
         if (stageOp != OP_NONE)
            weight_d <= result;
      end else begin
         weight_en <= 1'b0;
         ltp_event <= 1'b0;
         ltd_event <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stdp_weight_update.sv
// Testbench for stdp_weight_update: the bench owns the synaptic weight
// register, and a spike-history model predicts every output cycle by cycle.
module tb_stdp_weight_update;

   localparam int WIN  = 6;
   localparam int LTP  = 2;
   localparam int LTD  = 1;
   localparam int WMAX = 255;
   localparam int WMIN = 0;

   // Stimulus encoding: {reset, active, pre_spike, post_spike}
   localparam logic [3:0] IDLE   = 4'b0100;
   localparam logic [3:0] PRE    = 4'b0110;
   localparam logic [3:0] POST   = 4'b0101;
   localparam logic [3:0] BOTH   = 4'b0111;
   localparam logic [3:0] OFFPRE = 4'b0010;
   localparam logic [3:0] RST    = 4'b1100;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       active = 1'b0;
   logic       pre_spike = 1'b0;
   logic       post_spike = 1'b0;
   logic [7:0] weightReg = 8'd0;
   logic [7:0] weight_d;
   logic       weight_en;
   logic       ltp_event;
   logic       ltd_event;

   logic       loadReq = 1'b0;
   logic [7:0] loadValue = 8'd0;

   int compared = 0;
   int mismatched = 0;

   // Reference model state: spike history in active-cycle indices
   int         modelWeight = 0;
   int         pendOp = 0;
   int         pendDelta = 0;
   int         lastPre = -1000;
   int         lastPost = -1000;
   int         idx = 0;
   logic       expEn = 1'b0;
   logic       expLtp = 1'b0;
   logic       expLtd = 1'b0;
   logic [7:0] expD = 8'd0;

   wire [10:0] dutOut = {weight_en, ltp_event, ltd_event, weight_d};
   wire [10:0] expOut = {expEn, expLtp, expLtd, expD};

   stdp_weight_update dut (
      .clk        (clk),
      .reset      (reset),
      .active     (active),
      .pre_spike  (pre_spike),
      .post_spike (post_spike),
      .weight_q   (weightReg),
      .weight_d   (weight_d),
      .weight_en  (weight_en),
      .ltp_event  (ltp_event),
      .ltd_event  (ltd_event)
   );

   always #5 clk = ~clk;

   // Synaptic weight register driven by the block's strobe; bench may preload it
   always @(posedge clk) begin
      if (loadReq)
         weightReg <= loadValue;
      else if (weight_en)
         weightReg <= weight_d;
   end

   function automatic int clampW(input int v);
      if (v > WMAX) return WMAX;
      if (v < WMIN) return WMIN;
      return v;
   endfunction

   // Advance the reference model across one clock edge using the current inputs
   task automatic modelStep();
      int preT;
      int postT;
      if (loadReq) modelWeight = int'(loadValue);
      if (reset) begin
         pendOp = 0; pendDelta = 0;
         expEn = 1'b0; expLtp = 1'b0; expLtd = 1'b0; expD = 8'd0;
         lastPre = -1000; lastPost = -1000;
      end else if (active) begin
         expEn  = (pendOp != 0);
         expLtp = (pendOp == 1);
         expLtd = (pendOp == 2);
         if (pendOp == 1) modelWeight = clampW(modelWeight + pendDelta);
         else if (pendOp == 2) modelWeight = clampW(modelWeight - pendDelta);
         if (pendOp != 0) expD = 8'(modelWeight);
         preT  = idx - lastPre - 1;
         postT = idx - lastPost - 1;
         if (preT > WIN + 1) preT = WIN + 1;
         if (postT > WIN + 1) postT = WIN + 1;
         pendOp = 0; pendDelta = 0;
         if (post_spike && !pre_spike && preT <= WIN) begin
            pendOp = 1; pendDelta = LTP * (WIN + 1 - preT);
         end else if (pre_spike && !post_spike && postT <= WIN) begin
            pendOp = 2; pendDelta = LTD * (WIN + 1 - postT);
         end
         if (pre_spike) lastPre = idx;
         if (post_spike) lastPost = idx;
         idx++;
      end else begin
         expEn = 1'b0; expLtp = 1'b0; expLtd = 1'b0;
      end
   endtask

   // Drive one cycle of inputs, cross the edge, and land at the next negedge
   task automatic applyStimulus(input logic [3:0] s);
      reset      = s[3];
      active     = s[2];
      pre_spike  = s[1];
      post_spike = s[0];
      modelStep();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(IDLE);
   endtask

   task automatic loadWeight(input logic [7:0] v);
      loadReq = 1'b1;
      loadValue = v;
      applyStimulus(IDLE);
      loadReq = 1'b0;
   endtask

   task automatic test_reset();
      applyStimulus(RST);
      applyStimulus(RST);
      compared++;
      if (dutOut !== 11'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs: got %h expected %h", dutOut, 11'd0);
      end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(i == 0 ? POST : IDLE);
         compared++;
         if (dutOut !== 11'd0) begin
            mismatched++;
            $display("[TB] FAIL post_alone[%0d]: got %h expected %h", i, dutOut, 11'd0);
         end
      end
   endtask

   task automatic test_ltp();
      logic [3:0] seq [5] = '{PRE, IDLE, POST, IDLE, IDLE};
      idle(8);
      loadWeight(8'd100);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(seq[i]);
         compared++;
         if (dutOut !== expOut) begin
            mismatched++;
            $display("[TB] FAIL ltp_model[%0d]: got %h expected %h", i, dutOut, expOut);
         end
         if (i == 3) begin
            compared++;
            if (dutOut !== {3'b110, 8'd112}) begin
               mismatched++;
               $display("[TB] FAIL ltp_write: got %h expected %h", dutOut, {3'b110, 8'd112});
            end
         end
         if (i == 4) begin
            compared++;
            if (weightReg !== 8'd112 || weight_en !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL ltp_register: got %0d en %b expected 112 en 0", weightReg, weight_en);
            end
         end
      end
   endtask

   task automatic test_ltd_and_clamp();
      logic [3:0] seqLtd [4] = '{POST, PRE, IDLE, IDLE};
      logic [3:0] seqLtp [4] = '{PRE, POST, IDLE, IDLE};
      idle(8);
      loadWeight(8'd3);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(seqLtd[i]);
         compared++;
         if (dutOut !== expOut) begin
            mismatched++;
            $display("[TB] FAIL ltd_model[%0d]: got %h expected %h", i, dutOut, expOut);
         end
         if (i == 2) begin
            compared++;
            if (dutOut !== {3'b101, 8'd0}) begin
               mismatched++;
               $display("[TB] FAIL ltd_clamp_low: got %h expected %h", dutOut, {3'b101, 8'd0});
            end
         end
      end
      idle(8);
      loadWeight(8'd250);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(seqLtp[i]);
         compared++;
         if (dutOut !== expOut) begin
            mismatched++;
            $display("[TB] FAIL ltp_high_model[%0d]: got %h expected %h", i, dutOut, expOut);
         end
         if (i == 2) begin
            compared++;
            if (dutOut !== {3'b110, 8'd255}) begin
               mismatched++;
               $display("[TB] FAIL ltp_clamp_high: got %h expected %h", dutOut, {3'b110, 8'd255});
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] seq [5] = '{PRE, POST, POST, IDLE, IDLE};
      idle(8);
      loadWeight(8'd100);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(seq[i]);
         compared++;
         if (dutOut !== expOut) begin
            mismatched++;
            $display("[TB] FAIL b2b_model[%0d]: got %h expected %h", i, dutOut, expOut);
         end
         if (i == 2 && dutOut !== {3'b110, 8'd114}) begin
            mismatched++;
            $display("[TB] FAIL b2b_first: got %h expected %h", dutOut, {3'b110, 8'd114});
         end
         if (i == 3 && dutOut !== {3'b110, 8'd126}) begin
            mismatched++;
            $display("[TB] FAIL b2b_forward: got %h expected %h", dutOut, {3'b110, 8'd126});
         end
         if (i == 2 || i == 3) compared++;
      end
      compared++;
      if (weightReg !== 8'd126) begin
         mismatched++;
         $display("[TB] FAIL b2b_register: got %0d expected 126", weightReg);
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0] seq [6] = '{BOTH, IDLE, IDLE, POST, IDLE, IDLE};
      idle(8);
      loadWeight(8'd100);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(seq[i]);
         compared++;
         if (dutOut !== expOut) begin
            mismatched++;
            $display("[TB] FAIL simul_model[%0d]: got %h expected %h", i, dutOut, expOut);
         end
         if (i < 4) begin
            compared++;
            if (weight_en !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL simul_no_write[%0d]: got en %b expected 0", i, weight_en);
            end
         end
         if (i == 4) begin
            compared++;
            if (dutOut !== {3'b110, 8'd110}) begin
               mismatched++;
               $display("[TB] FAIL simul_later_ltp: got %h expected %h", dutOut, {3'b110, 8'd110});
            end
         end
      end
   endtask

   task automatic test_inactive();
      logic [3:0] seq [5] = '{PRE, POST, OFFPRE, IDLE, IDLE};
      idle(8);
      loadWeight(8'd100);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(seq[i]);
         compared++;
         if (dutOut !== expOut) begin
            mismatched++;
            $display("[TB] FAIL inactive_model[%0d]: got %h expected %h", i, dutOut, expOut);
         end
         if (i == 2) begin
            compared++;
            if (weight_en !== 1'b0) begin
               mismatched++;
               $display("[TB] FAIL inactive_hold: got en %b expected 0", weight_en);
            end
         end
         if (i == 3) begin
            compared++;
            if (dutOut !== {3'b110, 8'd114}) begin
               mismatched++;
               $display("[TB] FAIL inactive_resume: got %h expected %h", dutOut, {3'b110, 8'd114});
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] seq [8] = '{PRE, POST, RST, IDLE, IDLE, POST, IDLE, IDLE};
      idle(8);
      loadWeight(8'd100);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(seq[i]);
         compared++;
         if (dutOut !== expOut) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_model[%0d]: got %h expected %h", i, dutOut, expOut);
         end
         if (i >= 2) begin
            compared++;
            if (dutOut !== 11'd0) begin
               mismatched++;
               $display("[TB] FAIL reset_mid_quiet[%0d]: got %h expected %h", i, dutOut, 11'd0);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] s;
      applyStimulus(RST);
      idle(8);
      loadWeight(8'($urandom_range(0, 255)));
      for (int i = 0; i < 600; i++) begin
         s[3] = ($urandom_range(0, 99) == 0);
         s[2] = ($urandom_range(0, 7) != 0);
         s[1] = ($urandom_range(0, 3) == 0);
         s[0] = ($urandom_range(0, 3) == 0);
         applyStimulus(s);
         compared++;
         if (dutOut !== expOut) begin
            mismatched++;
            $display("[TB] FAIL random_outputs[%0d]: got %h expected %h", i, dutOut, expOut);
         end
         if (!expEn) begin
            compared++;
            if (int'(weightReg) !== modelWeight) begin
               mismatched++;
               $display("[TB] FAIL random_weight[%0d]: got %0d expected %0d", i, weightReg, modelWeight);
            end
         end
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      test_reset();
      test_ltp();
      test_ltd_and_clamp();
      test_back_to_back();
      test_simultaneous();
      test_inactive();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
